relu_maxpool_col: RTL
=====================

# relu_maxpool_col

Layer-0 post-processing stage that sits directly downstream of the 5×5 FP16 convolution column engine. It consumes one 24-row output column per `col_valid` strobe, applies ReLU, and performs 2×2 / stride-2 max pooling across row pairs and column pairs. It emits one 12-row pooled column for every two input columns, ready for the layer-1 feature-map writer.

## Interface
- `DATA_WIDTH`, 16: FP16 element width.
- `IN_ROWS`, 24: rows per input column (IMAGE_SIZE − KERNEL_SIZE + 1); must be even.
- `IN_COLS`, 24: input columns per frame; must be even.
- `COLNUM_W`, 6: width of `col_num` ($clog2(28)+1).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin frame; honoured only in IDLE.
- `col_valid` in 1: one-cycle strobe; `col_data`/`col_num` valid this cycle.
- `col_num` in COLNUM_W: 1-based conv output column index (1..IN_COLS).
- `col_data` in DATA_WIDTH × IN_ROWS: unpacked array [IN_ROWS-1:0], raw FP16.
- `frame_done_in` in 1: upstream conv `done` pulse.
- `pool_valid` out 1: one-cycle strobe, pooled column present.
- `pool_col` out $clog2(IN_COLS/2): 0-based pooled column index; doubles as writer address.
- `pool_data` out DATA_WIDTH × IN_ROWS/2: unpacked array [IN_ROWS/2-1:0].
- `busy` out 1: high in any state except IDLE.
- `seq_err` out 1: sticky column-sequence error; cleared by `start` or `rst`.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- ReLU per element `x`, applied on input before storage: result is 16'h0000 if sign=1 (incl. −0, −inf), or if NaN (exp=5'h1F, mant≠0); otherwise `x`.
- After ReLU all values are non-negative, so max = unsigned integer compare on the 16-bit pattern; ties pick either (bit-identical).
- `pool_data[r] = max(A[2r], A[2r+1], B[2r], B[2r+1])`, where A = held odd column and B = following even column.
- FSM states: IDLE, COLLECT_A (no column held), COLLECT_B (odd column held in register bank `held`, index `held_num`), FINISH.
- IDLE: `start` → COLLECT_A; clears `seq_err`. `col_valid` is ignored.
- COLLECT_A, `col_valid`:
  - odd `col_num`: store ReLU'd column and index → COLLECT_B.
  - even `col_num`: drop, set `seq_err`, stay.
- COLLECT_B, `col_valid`:
  - `col_num == held_num+1`: compute pool, register outputs with `pool_col = held_num>>1` → COLLECT_A.
  - other odd value: replace held column, set `seq_err`, stay.
  - anything else: drop, set `seq_err` → COLLECT_A.
- `col_num` of 0 or > IN_COLS is always treated as a sequence error and dropped.
- `frame_done_in` in COLLECT_A/B → FINISH. If in COLLECT_B, the held column is discarded and `seq_err` is set.
- Simultaneous `col_valid` and `frame_done_in`: the column is processed first (pairing/emission occurs), then → FINISH. `seq_err` is evaluated against the post-column state.
- FINISH: `done`=1 for exactly one cycle → IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `pool_valid`=0, `pool_col`=0, `pool_data`=all 0, `busy`=0, `seq_err`=0, `done`=0; FSM=IDLE; `held` cleared.
- Latency: pairing `col_valid` at edge N → `pool_valid`/`pool_data`/`pool_col` registered, visible after edge N, held until the next emission. `pool_valid` is high for one cycle only.
- No backpressure in either direction; strobes may arrive on consecutive cycles (back-to-back odd/even accepted).
- `done` asserts the cycle after FINISH is entered, i.e. two edges after `frame_done_in` is sampled.
- Async `rst` mid-frame: all state cleared immediately; no partial `pool_valid` or `done` after release.

## Structure
- Shared package `layer0_pkg`: `fp16_t` typedef, `FP16_ZERO`, the `is_nan_fp16` / `relu_fp16` functions, the FSM enum `pool_state_t`.
- One sub-module, `max4_fp16_pos`: combinational 4-input unsigned max; instantiated IN_ROWS/2 times via generate.
- Estimated RTL: ~180 lines.

## Test plan
- Nominal frame: `start`; columns 1..24 with `col_data[r] = {r, col}` encoded as positive FP16 → 12 `pool_valid` pulses, `pool_col` 0..11, each value the row/column pair maximum; `done` after `frame_done_in`; `seq_err`=0.
- ReLU: column 1 all 16'hBC00 (−1.0), column 2 all 16'h8000 (−0) → `pool_data` all 16'h0000. Pair of 16'h7E00 (NaN) with 16'h3C00 → 16'h3C00.
- Max select: rows 0/1 of columns 3/4 = 16'h3C00, 16'h4000, 16'h3800, 16'h7C00 → `pool_data[0]`=16'h7C00, `pool_col`=1.
- Sequence error: columns 1, then 4 → no `pool_valid`, `seq_err`=1. A later `start` in IDLE clears it.
- Simultaneous: column 24 together with `frame_done_in` → `pool_valid` with `pool_col`=11 next cycle, `done` one cycle later.
- Async `rst` asserted between columns 5 and 6 → all outputs 0 immediately; columns fed after release without `start` produce nothing.

Source files
------------

// File: rtl/layer0_pkg.sv
// Shared layer-0 types and FP16 helpers: element typedef, ReLU/NaN functions and the
// pooling FSM state encoding.
package layer0_pkg;

  localparam int unsigned FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StCollectA,
    StCollectB,
    StFinish
  } pool_state_t;

  function automatic logic is_nan_fp16(fp16_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  // Negatives (including -0 and -inf) and any NaN collapse to +0.
  function automatic fp16_t relu_fp16(fp16_t x);
    return (x[15] || is_nan_fp16(x)) ? FP16_ZERO : x;
  endfunction

endpackage

// File: rtl/relu_maxpool_col_if.sv
// Column-in / pooled-column-out bundle between the conv column engine, the pooling stage
// and the layer-1 writer.
interface relu_maxpool_col_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_ROWS    = 24,
  parameter int unsigned IN_COLS    = 24,
  parameter int unsigned COLNUM_W   = 6
);

  localparam int unsigned PoolColW = $clog2(IN_COLS / 2);

  logic                  start;
  logic                  col_valid;
  logic [COLNUM_W-1:0]   col_num;
  logic [DATA_WIDTH-1:0] col_data [IN_ROWS-1:0];
  logic                  frame_done_in;

  logic                  pool_valid;
  logic [PoolColW-1:0]   pool_col;
  logic [DATA_WIDTH-1:0] pool_data [IN_ROWS/2-1:0];
  logic                  busy;
  logic                  seq_err;
  logic                  done;

  modport master (
    output start, col_valid, col_num, col_data, frame_done_in,
    input  pool_valid, pool_col, pool_data, busy, seq_err, done
  );

  modport slave (
    input  start, col_valid, col_num, col_data, frame_done_in,
    output pool_valid, pool_col, pool_data, busy, seq_err, done
  );

endinterface

// File: rtl/max4_fp16_pos.sv
// Four-input max for non-negative FP16 values; the bit pattern orders like an unsigned int.
module max4_fp16_pos
  import layer0_pkg::*;
(
  input  fp16_t a_i,
  input  fp16_t b_i,
  input  fp16_t c_i,
  input  fp16_t d_i,
  output fp16_t max_o
);

  fp16_t ab_max;
  fp16_t cd_max;

  always_comb begin
    ab_max = (a_i > b_i) ? a_i : b_i;
    cd_max = (c_i > d_i) ? c_i : d_i;
    max_o  = (ab_max > cd_max) ? ab_max : cd_max;
  end

endmodule

// File: rtl/relu_maxpool_col.sv
// ReLU plus 2x2/stride-2 max pooling over a stream of conv output columns; holds one odd
// column and emits a pooled column when its even partner arrives.
module relu_maxpool_col
  import layer0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_ROWS    = 24,
  parameter int unsigned IN_COLS    = 24,
  parameter int unsigned COLNUM_W   = 6
) (
  input logic               clk,
  input logic               rst,
  relu_maxpool_col_if.slave bus
);

  localparam int unsigned OutRows  = IN_ROWS / 2;
  localparam int unsigned PoolColW = $clog2(IN_COLS / 2);

  pool_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] held_q [IN_ROWS];
  logic [DATA_WIDTH-1:0] held_d [IN_ROWS];
  logic [COLNUM_W-1:0]   held_num_q, held_num_d;
  logic                  seq_err_q, seq_err_d;
  logic                  done_q, done_d;
  logic                  pool_valid_q, pool_valid_d;
  logic [PoolColW-1:0]   pool_col_q, pool_col_d;
  logic [DATA_WIDTH-1:0] pool_data_q [OutRows];
  logic [DATA_WIDTH-1:0] pool_data_d [OutRows];

  logic [DATA_WIDTH-1:0] relu_col [IN_ROWS];
  logic [DATA_WIDTH-1:0] max_col  [OutRows];
  logic                  num_ok;
  logic                  num_odd;
  logic                  num_pairs;

  assign num_ok    = (bus.col_num != '0) && (bus.col_num <= COLNUM_W'(IN_COLS));
  assign num_odd   = bus.col_num[0];
  assign num_pairs = (bus.col_num == COLNUM_W'(held_num_q + COLNUM_W'(1)));

  always_comb begin
    for (int r = 0; r < IN_ROWS; r++) begin
      relu_col[r] = relu_fp16(bus.col_data[r]);
    end
  end

  for (genvar g = 0; g < OutRows; g++) begin : g_max
    max4_fp16_pos u_max (
      .a_i  (held_q[2*g]),
      .b_i  (held_q[2*g+1]),
      .c_i  (relu_col[2*g]),
      .d_i  (relu_col[2*g+1]),
      .max_o(max_col[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      held_q       <= '{default: FP16_ZERO};
      held_num_q   <= '0;
      seq_err_q    <= 1'b0;
      done_q       <= 1'b0;
      pool_valid_q <= 1'b0;
      pool_col_q   <= '0;
      pool_data_q  <= '{default: FP16_ZERO};
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      held_num_q   <= held_num_d;
      seq_err_q    <= seq_err_d;
      done_q       <= done_d;
      pool_valid_q <= pool_valid_d;
      pool_col_q   <= pool_col_d;
      pool_data_q  <= pool_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    held_num_d   = held_num_q;
    seq_err_d    = seq_err_q;
    done_d       = 1'b0;
    pool_valid_d = 1'b0;
    pool_col_d   = pool_col_q;
    pool_data_d  = pool_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StCollectA;
          seq_err_d = 1'b0;
        end
      end

      StCollectA, StCollectB: begin
        if (bus.col_valid) begin
          if (state_q == StCollectA) begin
            if (num_ok && num_odd) begin
              held_d     = relu_col;
              held_num_d = bus.col_num;
              state_d    = StCollectB;
            end else begin
              seq_err_d = 1'b1;
            end
          end else if (num_ok && num_pairs) begin
            pool_valid_d = 1'b1;
            pool_col_d   = PoolColW'(held_num_q >> 1);
            pool_data_d  = max_col;
            state_d      = StCollectA;
          end else if (num_ok && num_odd) begin
            held_d     = relu_col;
            held_num_d = bus.col_num;
            seq_err_d  = 1'b1;
          end else begin
            seq_err_d = 1'b1;
            state_d   = StCollectA;
          end
        end
        // Frame end is judged against the state left after any same-cycle column.
        if (bus.frame_done_in) begin
          if (state_d == StCollectB) begin
            seq_err_d = 1'b1;
            held_d    = '{default: FP16_ZERO};
          end
          state_d = StFinish;
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.done       = done_q;
    bus.seq_err    = seq_err_q;
    bus.pool_valid = pool_valid_q;
    bus.pool_col   = pool_col_q;
    for (int r = 0; r < OutRows; r++) begin
      bus.pool_data[r] = pool_data_q[r];
    end
  end

endmodule
